// File: rtl/f36_pkg.sv
// rtl/f36_pkg.sv - f36 word field positions and tx arbiter state encoding
package f36_pkg;
  localparam int F36_SOF    = 32;
  localparam int F36_EOF    = 33;
  localparam int F36_OCC_LO = 34;

  // Word injected to close a frame whose source stalled: EOF set, no SOF, zero payload
  localparam logic [35:0] F36_ABORT_WORD = {2'b00, 1'b1, 1'b0, 32'h0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin picker: first set request bit after index 'last', wrapping
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last,
  output logic         valid,
  output logic [1:0]   idx
);
  logic found;

  always_comb begin
    valid = |req;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((int'(last) + k) % N) == i)) begin
          idx   = 2'(i);
          found = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/f36_tx_arbiter.sv
// rtl/f36_tx_arbiter.sv - shares one f36 tx link between NUM_SRC packet sources,
// switching only at frame boundaries, with a stall watchdog that force-closes frames
module f36_tx_arbiter
  import f36_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_SRC*36-1:0] in_data,
  input  logic [NUM_SRC-1:0]    in_src_rdy,
  output logic [NUM_SRC-1:0]    in_dst_rdy,
  output logic [35:0]           out_data,
  output logic                  out_src_rdy,
  input  logic                  out_dst_rdy,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  sof_err,
  output logic                  abort,
  output logic [NUM_SRC*CW-1:0] pkt_cnt,
  output logic [CW-1:0]         abort_cnt
);
  localparam int            SW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STALL_MAX = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic          WD_EN     = (TIMEOUT > 0);
  localparam logic [1:0]    GRANT_RST = 2'(NUM_SRC - 1);

  arb_state_e    state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          first_q, first_d;
  logic          started_q, started_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [CW-1:0] pkt_cnt_q [NUM_SRC];
  logic [CW-1:0] pkt_cnt_d [NUM_SRC];
  logic [CW-1:0] abort_cnt_q, abort_cnt_d;
  logic          sof_err_q, sof_err_d;
  logic          abort_q, abort_d;

  logic          pick_valid;
  logic [1:0]    pick_idx;
  logic [35:0]   sel_data;
  logic          sel_rdy;
  logic          xfer;

  rr_pick #(.N(NUM_SRC)) u_pick (
    .req   (in_src_rdy),
    .last  (grant_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_data = '0;
    sel_rdy  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == 2'(i)) begin
        sel_data = in_data[36*i +: 36];
        sel_rdy  = in_src_rdy[i];
      end
    end
  end

  always_comb begin
    out_data    = '0;
    out_src_rdy = 1'b0;
    in_dst_rdy  = '0;
    case (state_q)
      ST_PASS: begin
        out_data    = sel_data;
        out_src_rdy = sel_rdy;
        for (int i = 0; i < NUM_SRC; i++) begin
          in_dst_rdy[i] = (grant_q == 2'(i)) && out_dst_rdy;
        end
      end
      ST_ABORT: begin
        out_data    = F36_ABORT_WORD;
        out_src_rdy = 1'b1;
      end
      default: ;
    endcase
  end

  assign xfer = (state_q == ST_PASS) && sel_rdy && out_dst_rdy;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    first_d     = first_q;
    started_d   = started_q;
    stall_d     = stall_q;
    pkt_cnt_d   = pkt_cnt_q;
    abort_cnt_d = abort_cnt_q;
    sof_err_d   = 1'b0;
    abort_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d   = pick_idx;
          state_d   = ST_PASS;
          first_d   = 1'b1;
          started_d = 1'b0;
          stall_d   = '0;
        end
      end
      ST_PASS: begin
        if (xfer) begin
          first_d   = 1'b0;
          started_d = 1'b1;
          stall_d   = '0;
          if (first_q && !sel_data[F36_SOF]) sof_err_d = 1'b1;
          if (sel_data[F36_EOF]) begin
            state_d = ST_IDLE;
            for (int i = 0; i < NUM_SRC; i++) begin
              if (grant_q == 2'(i)) pkt_cnt_d[i] = pkt_cnt_q[i] + CW'(1);
            end
          end
        // Only a silent source counts as stalled; downstream backpressure never does
        end else if (WD_EN && started_q && !sel_rdy) begin
          if (stall_q == STALL_MAX) state_d = ST_ABORT;
          else                      stall_d = stall_q + SW'(1);
        end
      end
      ST_ABORT: begin
        if (out_dst_rdy) begin
          abort_d     = 1'b1;
          abort_cnt_d = abort_cnt_q + CW'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= GRANT_RST;
      first_q     <= 1'b0;
      started_q   <= 1'b0;
      stall_q     <= '0;
      abort_cnt_q <= '0;
      sof_err_q   <= 1'b0;
      abort_q     <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) pkt_cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      first_q     <= first_d;
      started_q   <= started_d;
      stall_q     <= stall_d;
      abort_cnt_q <= abort_cnt_d;
      sof_err_q   <= sof_err_d;
      abort_q     <= abort_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign sof_err   = sof_err_q;
  assign abort     = abort_q;
  assign abort_cnt = abort_cnt_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_pkt_cnt
    assign pkt_cnt[CW*g +: CW] = pkt_cnt_q[g];
  end
endmodule

// File: doc/f36_tx_arbiter.md
Name: f36_tx_arbiter

Overview:
- Shares the GEMAC wrapper's single tx_f36 input between NUM_SRC packet sources (packet_sender, a future ARP/echo responder, etc.).
- Grants round-robin at packet boundaries only; frames are never interleaved.
- Forwards the granted source combinationally.
- Guards against a source stalling mid-frame by force-terminating the frame after TIMEOUT idle cycles.
- Sits in the dsp_clk domain between the packet sources and simple_gemac_wrapper.

Parameters:
- NUM_SRC, 2, number of requesters (2..4).
- TIMEOUT, 1024, source-stall cycles before abort (0 = watchdog disabled).
- CW, 16, width of per-source packet counters and the abort counter.

Ports:
- clk, in, 1, dsp_clk.
- reset_n, in, 1, asynchronous active-low reset.
- in_data, in, NUM_SRC*36, f36 words; source i occupies [36*i+35:36*i]; bit32=SOF, bit33=EOF, bits35:34=occupancy.
- in_src_rdy, in, NUM_SRC, per-source valid.
- in_dst_rdy, out, NUM_SRC, per-source ready.
- out_data, out, 36, to tx_f36_data.
- out_src_rdy, out, 1, to tx_f36_src_rdy.
- out_dst_rdy, in, 1, from tx_f36_dst_rdy.
- grant, out, 2, index of the current/last granted source.
- busy, out, 1, high while in PASS or ABORT.
- sof_err, out, 1, one-cycle pulse: first word of a grant lacked SOF.
- abort, out, 1, one-cycle pulse: watchdog terminated a frame.
- pkt_cnt, out, NUM_SRC*CW, per-source completed-frame counters (wrap).
- abort_cnt, out, CW, total aborts (wraps).

Behaviour:
- Reset (async, reset_n=0): state IDLE, grant=NUM_SRC-1 (so source 0 has first priority), all counters 0, all outputs 0.
- A word transfers on a rising clk when valid and ready are both high on the same link.
- IDLE:
  - out_src_rdy=0; in_dst_rdy=0.
  - If any in_src_rdy is set, pick the first set bit searching from grant+1 modulo NUM_SRC, register it into grant, and go to PASS.
  - One-cycle arbitration bubble; no data moves in IDLE.
- PASS:
  - Zero-latency mux: out_data=in_data[grant], out_src_rdy=in_src_rdy[grant], in_dst_rdy[grant]=out_dst_rdy; other in_dst_rdy=0.
  - A first_word flag is set on entry. On the first transfer, if bit32=0, pulse sof_err; the word is still forwarded.
  - A transfer with bit33=1: increment pkt_cnt[grant] and go to IDLE. The next arbitration starts from grant+1, so a continuously requesting source alternates with others.
  - A word with both SOF and EOF is a complete one-word frame.
- Watchdog (PASS only, TIMEOUT>0):
  - The stall counter clears on entry and on every transfer.
  - It increments only when in_src_rdy[grant]=0 and at least one word of the frame has transferred.
  - Backpressure (out_dst_rdy=0) never counts.
  - When the counter reaches TIMEOUT-1 while still stalled, go to ABORT next cycle.
- ABORT:
  - in_dst_rdy=0 for all sources.
  - out_data={2'b00,1'b1,1'b0,32'h0} (EOF only), out_src_rdy=1.
  - On out_dst_rdy=1: pulse abort, increment abort_cnt, go to IDLE.
  - The remaining words of the aborted frame from that source are later seen as a new grant, which raises sof_err; this is expected.
- Simultaneous events: an EOF transfer in the same cycle the watchdog would fire counts as EOF. Requests arriving during PASS/ABORT wait.
- Pulses (sof_err, abort) last exactly one cycle.
- Counter width: CW; wrap at 2^CW-1 -> 0.
- Reset mid-frame: the MAC sees the frame truncated. The GEMAC FIFO handles recovery; no special action is required here.

Decomposition:
- Package f36_pkg: F36_SOF=32, F36_EOF=33, F36_OCC_LO=34 constants; state encoding IDLE/PASS/ABORT.
- Sub-module rr_pick (NUM_SRC-wide round-robin first-set-after-index picker, combinational) instantiated once.
- Counters, watchdog and mux stay in the top.

Test Plan:
- Single source: src0 sends 4-word frame (SOF on w0, EOF on w3), out_dst_rdy=1. Expect words appear same cycle as in_src_rdy after a 1-cycle IDLE bubble, pkt_cnt[0]=1, grant=0, busy falls after EOF.
- Contention: src0 and src1 both hold 3-word frames continuously for 4 frames each. Expect output order 0,1,0,1,... with no interleaving, and pkt_cnt = 4/4.
- Backpressure: out_dst_rdy toggles 1,0,1,0 during a 5-word frame. Expect no word lost or duplicated, in_dst_rdy[1]=0 throughout, and the watchdog silent with TIMEOUT=4.
- Stall abort (TIMEOUT=8): src1 sends SOF word then drops src_rdy. Expect an EOF-only word (data 0x2_0000_0000) 8 cycles later, abort pulse, abort_cnt=1, pkt_cnt[1]=0. Resuming src1 words then raise sof_err.
- Missing SOF: src0's first word has bit32=0. Expect sof_err pulse on that transfer and the word still forwarded.
- Async reset asserted mid-frame: expect outputs 0 immediately and grant=NUM_SRC-1. After release, src0 wins first arbitration when src0 and src1 request together.
